can_fault_confinement: RTL and testbench

// Fault-confinement controller and error-frame sequencer for the CAN node; the consumer of can_error_detection outputs.
// - Turns detected errors into TEC/REC updates.
// - Derives error-active / error-passive / bus-off state.
// - Sequences the error frame (flag, then delimiter) by overriding the transmit bit.
// - Drives sending_error_flag_passive back to the error detector.

---
 rtl/can_fault_confinement.sv | 223 ++++++++++++++++++++++
 tb/tb_can_fault_confinement.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_fault_confinement.sv
// CAN fault confinement: TEC/REC bookkeeping, error-active/passive/bus-off
// decode, and error-frame sequencing by overriding the transmit bit.
module can_fault_confinement #(
    parameter int PASSIVE_LIM = 128,
    parameter int BUSOFF_LIM  = 256,
    parameter int FLAG_LEN    = 6,
    parameter int DELIM_LEN   = 8,
    parameter int RECOV_SEQS  = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_point,
    input  logic       rx_bit,
    input  logic       tx_active,
    input  logic       bit_error,
    input  logic       stuff_error,
    input  logic       crc_error,
    input  logic       form_error,
    input  logic       ack_error,
    input  logic       tx_success,
    input  logic       rx_success,
    output logic [8:0] tec,
    output logic [7:0] rec,
    output logic [1:0] error_state,
    output logic       tx_override_en,
    output logic       tx_override_bit,
    output logic       sending_error_flag_passive,
    output logic       error_frame_done
);

    localparam int CNT_W = $clog2((FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN) + 1;

    localparam logic [8:0]       TEC_PASSIVE = 9'(PASSIVE_LIM);
    localparam logic [7:0]       REC_PASSIVE = 8'(PASSIVE_LIM);
    localparam logic [8:0]       TEC_BUSOFF  = 9'(BUSOFF_LIM);
    localparam logic [CNT_W-1:0] FLAG_LAST   = CNT_W'(FLAG_LEN - 1);
    localparam logic [CNT_W-1:0] DELIM_LAST  = CNT_W'(DELIM_LEN - 1);
    localparam logic [CNT_W-1:0] DOM_LAST    = CNT_W'(7);
    localparam logic [3:0]       RUN_LAST    = 4'd10;
    localparam logic [7:0]       SEQ_LAST    = 8'(RECOV_SEQS - 1);

    localparam logic [1:0] ES_ACTIVE  = 2'b00;
    localparam logic [1:0] ES_PASSIVE = 2'b01;
    localparam logic [1:0] ES_BUSOFF  = 2'b10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FLAG       = 3'd1,
        DELIM_WAIT = 3'd2,
        DELIM      = 3'd3,
        BUSOFF     = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [8:0]       tec_n;
    logic [7:0]       rec_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic             is_tx, is_tx_n;
    logic             passive, passive_n;
    logic [3:0]       run_cnt, run_n;
    logic [7:0]       seq_cnt, seq_n;
    logic             done_n;

    logic             err_any;
    logic [8:0]       tec_plus8;
    logic [7:0]       rec_plus1;
    logic [7:0]       rec_plus8;

    assign err_any   = bit_error | stuff_error | crc_error | form_error | ack_error;
    assign tec_plus8 = (tec >= TEC_BUSOFF - 9'd8) ? TEC_BUSOFF : tec + 9'd8;
    assign rec_plus1 = (rec == 8'hff) ? rec : rec + 8'd1;
    assign rec_plus8 = (rec >= 8'd247) ? 8'hff : rec + 8'd8;

    always_comb begin
        if (tec >= TEC_BUSOFF || state == BUSOFF)
            error_state = ES_BUSOFF;
        else if (tec >= TEC_PASSIVE || rec >= REC_PASSIVE)
            error_state = ES_PASSIVE;
        else
            error_state = ES_ACTIVE;
    end

    always_comb begin
        state_n   = state;
        tec_n     = tec;
        rec_n     = rec;
        bit_cnt_n = bit_cnt;
        is_tx_n   = is_tx;
        passive_n = passive;
        run_n     = run_cnt;
        seq_n     = seq_cnt;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (err_any) begin
                    // Error beats any success pulse arriving in the same cycle.
                    if (tx_active) begin
                        if (!(ack_error && error_state == ES_PASSIVE))
                            tec_n = tec_plus8;
                    end else begin
                        rec_n = rec_plus1;
                    end
                    state_n   = FLAG;
                    is_tx_n   = tx_active;
                    passive_n = (error_state == ES_PASSIVE);
                    bit_cnt_n = '0;
                end else begin
                    if (tx_success && tec != 9'd0)
                        tec_n = tec - 9'd1;
                    if (rx_success) begin
                        if (rec > 8'd127)
                            rec_n = 8'd120;
                        else if (rec != 8'd0)
                            rec_n = rec - 8'd1;
                    end
                end
            end
            FLAG: begin
                if (bit_error && !passive) begin
                    if (is_tx) tec_n = tec_plus8;
                    else       rec_n = rec_plus8;
                end
                if (sample_point) begin
                    if (bit_cnt == FLAG_LAST) begin
                        state_n   = DELIM_WAIT;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            DELIM_WAIT: begin
                // bit_cnt counts consecutive dominant bits; recessive starts the delimiter.
                if (sample_point) begin
                    if (rx_bit) begin
                        state_n   = DELIM;
                        bit_cnt_n = CNT_W'(1);
                    end else if (bit_cnt == DOM_LAST) begin
                        bit_cnt_n = '0;
                        if (is_tx) tec_n = tec_plus8;
                        else       rec_n = rec_plus8;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            DELIM: begin
                if (sample_point) begin
                    if (!rx_bit) begin
                        if (is_tx) tec_n = tec_plus8;
                        else       rec_n = rec_plus1;
                        state_n   = FLAG;
                        passive_n = (error_state == ES_PASSIVE);
                        bit_cnt_n = '0;
                    end else if (bit_cnt == DELIM_LAST) begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                        done_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            BUSOFF: begin
                if (sample_point) begin
                    if (!rx_bit) begin
                        run_n = '0;
                    end else if (run_cnt == RUN_LAST) begin
                        run_n = '0;
                        if (seq_cnt == SEQ_LAST) begin
                            seq_n   = '0;
                            tec_n   = '0;
                            rec_n   = '0;
                            state_n = IDLE;
                        end else begin
                            seq_n = seq_cnt + 8'd1;
                        end
                    end else begin
                        run_n = run_cnt + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Reaching the bus-off limit aborts whatever frame is in progress.
        if (state != BUSOFF && tec_n >= TEC_BUSOFF) begin
            state_n   = BUSOFF;
            bit_cnt_n = '0;
            run_n     = '0;
            seq_n     = '0;
            done_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            tec              <= '0;
            rec              <= '0;
            bit_cnt          <= '0;
            is_tx            <= 1'b0;
            passive          <= 1'b0;
            run_cnt          <= '0;
            seq_cnt          <= '0;
            error_frame_done <= 1'b0;
        end else begin
            state            <= state_n;
            tec              <= tec_n;
            rec              <= rec_n;
            bit_cnt          <= bit_cnt_n;
            is_tx            <= is_tx_n;
            passive          <= passive_n;
            run_cnt          <= run_n;
            seq_cnt          <= seq_n;
            error_frame_done <= done_n;
        end
    end

    assign tx_override_en             = (state != IDLE);
    assign tx_override_bit            = (state == FLAG) ? passive : 1'b1;
    assign sending_error_flag_passive = (state == FLAG) && passive;

endmodule

// File: tb/tb_can_fault_confinement.sv
// Directed bench for can_fault_confinement: counters, state decode,
// error-frame sequencing and bus-off recovery.
module tb_can_fault_confinement;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_point = 1'b0;
    logic       rx_bit = 1'b1;
    logic       tx_active = 1'b0;
    logic       bit_error = 1'b0;
    logic       stuff_error = 1'b0;
    logic       crc_error = 1'b0;
    logic       form_error = 1'b0;
    logic       ack_error = 1'b0;
    logic       tx_success = 1'b0;
    logic       rx_success = 1'b0;
    logic [8:0] tec;
    logic [7:0] rec;
    logic [1:0] error_state;
    logic       tx_override_en;
    logic       tx_override_bit;
    logic       sending_error_flag_passive;
    logic       error_frame_done;

    int errors = 0;
    int checks = 0;

    can_fault_confinement dut (
        .clk                        (clk),
        .rst                        (rst),
        .sample_point               (sample_point),
        .rx_bit                     (rx_bit),
        .tx_active                  (tx_active),
        .bit_error                  (bit_error),
        .stuff_error                (stuff_error),
        .crc_error                  (crc_error),
        .form_error                 (form_error),
        .ack_error                  (ack_error),
        .tx_success                 (tx_success),
        .rx_success                 (rx_success),
        .tec                        (tec),
        .rec                        (rec),
        .error_state                (error_state),
        .tx_override_en             (tx_override_en),
        .tx_override_bit            (tx_override_bit),
        .sending_error_flag_passive (sending_error_flag_passive),
        .error_frame_done           (error_frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        {bit_error, stuff_error, crc_error, form_error, ack_error} = 5'b0;
        {tx_success, rx_success, sample_point, tx_active} = 4'b0;
        rx_bit = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic sample(input logic b);
        sample_point = 1'b1;
        rx_bit = b;
        tick();
        sample_point = 1'b0;
        rx_bit = 1'b1;
    endtask

    task automatic samples(input logic b, input int n);
        for (int i = 0; i < n; i++) sample(b);
    endtask

    // e = {bit, stuff, crc, form, ack}
    task automatic err_pulse(input logic [4:0] e, input logic tx);
        {bit_error, stuff_error, crc_error, form_error, ack_error} = e;
        tx_active = tx;
        tick();
        {bit_error, stuff_error, crc_error, form_error, ack_error} = 5'b0;
    endtask

    task automatic finish_frame();
        samples(1'b0, 6);
        samples(1'b1, 8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (tec !== 9'd0 || rec !== 8'd0 || error_state !== 2'b00) begin
            errors++;
            $display("FAIL reset_counters: tec=%0d rec=%0d es=%b expected 0 0 00", tec, rec, error_state);
        end
        checks++;
        if (tx_override_en !== 1'b0 || tx_override_bit !== 1'b1 ||
            sending_error_flag_passive !== 1'b0 || error_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b bit=%b sefp=%b done=%b expected 0 1 0 0",
                     tx_override_en, tx_override_bit, sending_error_flag_passive, error_frame_done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rx_error_frame();
        int bad_flag;
        err_pulse(5'b01000, 1'b0);
        checks++;
        if (rec !== 8'd1 || tec !== 9'd0) begin
            errors++;
            $display("FAIL t1_rec_inc: rec=%0d tec=%0d expected 1 0", rec, tec);
        end
        bad_flag = 0;
        for (int i = 0; i < 6; i++) begin
            if (tx_override_en !== 1'b1 || tx_override_bit !== 1'b0) bad_flag++;
            sample(1'b0);
        end
        checks++;
        if (bad_flag != 0) begin
            errors++;
            $display("FAIL t1_active_flag: %0d flag bits wrong, expected 6 dominant override bits", bad_flag);
        end
        checks++;
        if (tx_override_en !== 1'b1 || tx_override_bit !== 1'b1) begin
            errors++;
            $display("FAIL t1_after_flag: en=%b bit=%b expected 1 1", tx_override_en, tx_override_bit);
        end
        samples(1'b1, 7);
        checks++;
        if (error_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL t1_done_early: done=%b after 7 delimiter bits expected 0", error_frame_done);
        end
        sample(1'b1);
        checks++;
        if (error_frame_done !== 1'b1) begin
            errors++;
            $display("FAIL t1_done: done=%b after 8 delimiter bits expected 1", error_frame_done);
        end
        tick();
        checks++;
        if (error_frame_done !== 1'b0 || tx_override_en !== 1'b0 || rec !== 8'd1) begin
            errors++;
            $display("FAIL t1_idle: done=%b en=%b rec=%0d expected 0 0 1",
                     error_frame_done, tx_override_en, rec);
        end
    endtask

    task automatic test_tec_passive();
        int bad_flag;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            err_pulse(5'b10000, 1'b1);
            finish_frame();
        end
        checks++;
        if (tec !== 9'd128 || error_state !== 2'b01) begin
            errors++;
            $display("FAIL t2_passive: tec=%0d es=%b expected 128 01", tec, error_state);
        end
        err_pulse(5'b10000, 1'b1);
        checks++;
        if (tec !== 9'd136) begin
            errors++;
            $display("FAIL t2_tec136: tec=%0d expected 136", tec);
        end
        bad_flag = 0;
        for (int i = 0; i < 6; i++) begin
            if (sending_error_flag_passive !== 1'b1 || tx_override_bit !== 1'b1 ||
                tx_override_en !== 1'b1) bad_flag++;
            sample(1'b0);
        end
        checks++;
        if (bad_flag != 0) begin
            errors++;
            $display("FAIL t2_passive_flag: %0d flag bits wrong, expected passive recessive flag", bad_flag);
        end
        checks++;
        if (sending_error_flag_passive !== 1'b0) begin
            errors++;
            $display("FAIL t2_flag_end: sefp=%b expected 0", sending_error_flag_passive);
        end
        samples(1'b1, 8);
    endtask

    task automatic test_ack_passive();
        for (int i = 0; i < 6; i++) begin
            tx_success = 1'b1;
            tick();
            tx_success = 1'b0;
        end
        checks++;
        if (tec !== 9'd130 || error_state !== 2'b01) begin
            errors++;
            $display("FAIL t3_tec130: tec=%0d es=%b expected 130 01", tec, error_state);
        end
        err_pulse(5'b00001, 1'b1);
        checks++;
        if (tec !== 9'd130 || tx_override_en !== 1'b1) begin
            errors++;
            $display("FAIL t3_ack_passive: tec=%0d en=%b expected 130 1", tec, tx_override_en);
        end
        finish_frame();
        tx_success = 1'b1;
        err_pulse(5'b10000, 1'b1);
        tx_success = 1'b0;
        checks++;
        if (tec !== 9'd138) begin
            errors++;
            $display("FAIL t3_err_wins: tec=%0d expected 138", tec);
        end
        finish_frame();
    endtask

    task automatic test_rec_success();
        apply_reset();
        err_pulse(5'b01000, 1'b0);
        for (int i = 0; i < 16; i++) err_pulse(5'b10000, 1'b0);
        finish_frame();
        checks++;
        if (rec !== 8'd129 || error_state !== 2'b01) begin
            errors++;
            $display("FAIL t4_rec129: rec=%0d es=%b expected 129 01", rec, error_state);
        end
        err_pulse(5'b00100, 1'b0);
        finish_frame();
        checks++;
        if (rec !== 8'd130) begin
            errors++;
            $display("FAIL t4_rec130: rec=%0d expected 130", rec);
        end
        rx_success = 1'b1;
        tick();
        rx_success = 1'b0;
        checks++;
        if (rec !== 8'd120 || error_state !== 2'b00) begin
            errors++;
            $display("FAIL t4_rec120: rec=%0d es=%b expected 120 00", rec, error_state);
        end
        for (int i = 0; i < 121; i++) begin
            rx_success = 1'b1;
            tick();
            rx_success = 1'b0;
        end
        checks++;
        if (rec !== 8'd0) begin
            errors++;
            $display("FAIL t4_rec_floor: rec=%0d expected 0", rec);
        end
    endtask

    task automatic test_delim_wait();
        apply_reset();
        err_pulse(5'b01000, 1'b0);
        samples(1'b0, 6);
        samples(1'b0, 8);
        checks++;
        if (rec !== 8'd9) begin
            errors++;
            $display("FAIL t5_dom8: rec=%0d expected 9", rec);
        end
        samples(1'b0, 8);
        checks++;
        if (rec !== 8'd17 || tx_override_bit !== 1'b1) begin
            errors++;
            $display("FAIL t5_dom16: rec=%0d bit=%b expected 17 1", rec, tx_override_bit);
        end
        samples(1'b1, 3);
        sample(1'b0);
        checks++;
        if (rec !== 8'd18 || tx_override_bit !== 1'b0 || error_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL t5_form_refl: rec=%0d bit=%b done=%b expected 18 0 0",
                     rec, tx_override_bit, error_frame_done);
        end
        finish_frame();
        checks++;
        if (error_frame_done !== 1'b1 || rec !== 8'd18) begin
            errors++;
            $display("FAIL t5_done: done=%b rec=%0d expected 1 18", error_frame_done, rec);
        end
    endtask

    task automatic test_busoff();
        apply_reset();
        err_pulse(5'b01000, 1'b0);
        finish_frame();
        for (int i = 0; i < 31; i++) begin
            err_pulse(5'b10000, 1'b1);
            finish_frame();
        end
        checks++;
        if (tec !== 9'd248 || error_state !== 2'b01 || rec !== 8'd1) begin
            errors++;
            $display("FAIL t6_tec248: tec=%0d es=%b rec=%0d expected 248 01 1", tec, error_state, rec);
        end
        err_pulse(5'b10000, 1'b1);
        checks++;
        if (tec !== 9'd256 || error_state !== 2'b10) begin
            errors++;
            $display("FAIL t6_busoff: tec=%0d es=%b expected 256 10", tec, error_state);
        end
        checks++;
        if (tx_override_en !== 1'b1 || tx_override_bit !== 1'b1 || sending_error_flag_passive !== 1'b0) begin
            errors++;
            $display("FAIL t6_abort: en=%b bit=%b sefp=%b expected 1 1 0",
                     tx_override_en, tx_override_bit, sending_error_flag_passive);
        end
        rx_success = 1'b1;
        err_pulse(5'b01000, 1'b0);
        rx_success = 1'b0;
        checks++;
        if (rec !== 8'd1 || tec !== 9'd256) begin
            errors++;
            $display("FAIL t6_ignore: rec=%0d tec=%0d expected 1 256", rec, tec);
        end
        samples(1'b1, 4);
        sample(1'b0);
        for (int r = 0; r < 127; r++) samples(1'b1, 11);
        samples(1'b1, 10);
        checks++;
        if (error_state !== 2'b10 || tec !== 9'd256) begin
            errors++;
            $display("FAIL t6_early_recov: es=%b tec=%0d expected 10 256", error_state, tec);
        end
        sample(1'b1);
        checks++;
        if (tec !== 9'd0 || rec !== 8'd0 || error_state !== 2'b00 || tx_override_en !== 1'b0) begin
            errors++;
            $display("FAIL t6_recovered: tec=%0d rec=%0d es=%b en=%b expected 0 0 00 0",
                     tec, rec, error_state, tx_override_en);
        end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        err_pulse(5'b01000, 1'b0);
        samples(1'b0, 2);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_override_en !== 1'b0 || tx_override_bit !== 1'b1 || rec !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_async: en=%b bit=%b rec=%0d expected 0 1 0",
                     tx_override_en, tx_override_bit, rec);
        end
        tick();
        rst = 1'b0;
        samples(1'b0, 3);
        checks++;
        if (tx_override_en !== 1'b0 || error_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release: en=%b done=%b expected 0 0", tx_override_en, error_frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_rx_error_frame();
        test_tec_passive();
        test_ack_passive();
        test_rec_success();
        test_delim_wait();
        test_busoff();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
